// File: rtl/sram_kn_arb_pkg.sv
// Shared types and constants for the K x N SRAM arbiter.
// Port IDs and the packed command bundle registered onto the SRAM.
package sram_kn_arb_pkg;

    localparam int PORT_LOADER   = 0;
    localparam int PORT_CONSUMER = 1;

    localparam int KMAX_DEF   = 1024;
    localparam int N_DEF      = 8;
    localparam int DATA_W_DEF = 32;
    localparam int BYTE_W_DEF = DATA_W_DEF / 8;
    localparam int K_W_DEF    = (KMAX_DEF <= 1) ? 1 : $clog2(KMAX_DEF);
    localparam int N_W_DEF    = (N_DEF <= 1) ? 1 : $clog2(N_DEF);

    typedef struct packed {
        logic                  we;
        logic [K_W_DEF-1:0]    k;
        logic [N_W_DEF-1:0]    n;
        logic [DATA_W_DEF-1:0] wdata;
        logic [BYTE_W_DEF-1:0] wmask;
    } kn_cmd_t;

endpackage

// File: rtl/sram_kn_tag_fifo.sv
// In-order FIFO of 1-bit requester IDs for reads in flight.
// An empty FIFO lets a same-cycle push pass straight to the pop side.
module sram_kn_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             push_id,
    input  logic             pop,
    output logic             pop_ok,
    output logic             pop_id,
    output logic             stray,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty, wr, rd, bypass;

    // Push/pop bookkeeping, including the empty-FIFO bypass
    always_comb begin
        empty    = (cnt_q == '0);
        bypass   = empty && push && pop;
        wr       = push && !bypass;
        rd       = pop && !empty;
        pop_ok   = rd || bypass;
        pop_id   = empty ? push_id : mem_q[rd_ptr_q];
        stray    = pop && empty && !push;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(wr) - CNT_W'(rd);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/sram_kn_arb.sv
// Round-robin arbiter sharing one K x N SRAM between loader and consumer.
// Registers the winning command and routes read data back in issue order.
module sram_kn_arb
    import sram_kn_arb_pkg::*;
#(
    parameter int KMAX    = KMAX_DEF,
    parameter int N       = N_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BYTE_W  = DATA_W / 8,
    parameter int MAX_OUT = 4,
    parameter int K_W     = (KMAX <= 1) ? 1 : $clog2(KMAX),
    parameter int N_W     = (N <= 1) ? 1 : $clog2(N),
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [K_W-1:0]    p0_k,
    input  logic [N_W-1:0]    p0_n,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [BYTE_W-1:0] p0_wmask,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_data,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [K_W-1:0]    p1_k,
    input  logic [N_W-1:0]    p1_n,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [BYTE_W-1:0] p1_wmask,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_data,
    output logic              x_en,
    output logic              x_re,
    output logic              x_we,
    output logic [K_W-1:0]    x_k,
    output logic [N_W-1:0]    x_n,
    output logic [DATA_W-1:0] x_wdata,
    output logic [BYTE_W-1:0] x_wmask,
    input  logic [DATA_W-1:0] x_rdata,
    input  logic              x_rvalid,
    output logic [CNT_W-1:0]  outstanding,
    output logic              err_stray
);

    logic             rd_room, elig0, elig1, acc, gnt_id;
    logic             push, pop_ok, pop_id, stray;
    logic [CNT_W-1:0] fifo_cnt;
    kn_cmd_t          sel_cmd, cmd_q, cmd_d;
    logic             issue_q, issue_d;
    logic             rr_last_q, rr_last_d;
    logic [1:0]       rsp_v_q, rsp_v_d;
    logic [DATA_W-1:0] rsp0_q, rsp0_d;
    logic [DATA_W-1:0] rsp1_q, rsp1_d;
    logic             err_q, err_d;

    // A returning read in this cycle frees a slot for a new read
    assign rd_room = (fifo_cnt < CNT_W'(MAX_OUT)) || x_rvalid;

    // Eligibility, round-robin grant and winning command select
    always_comb begin
        elig0  = rst && p0_valid && (p0_we || rd_room);
        elig1  = rst && p1_valid && (p1_we || rd_room);
        acc    = elig0 || elig1;
        gnt_id = 1'(PORT_LOADER);
        if (elig0 && elig1) begin
            gnt_id = ~rr_last_q;
        end else if (elig1) begin
            gnt_id = 1'(PORT_CONSUMER);
        end
        p0_ready = acc && (gnt_id == 1'(PORT_LOADER));
        p1_ready = acc && (gnt_id == 1'(PORT_CONSUMER));
        if (gnt_id == 1'(PORT_CONSUMER)) begin
            sel_cmd.we    = p1_we;
            sel_cmd.k     = p1_k;
            sel_cmd.n     = p1_n;
            sel_cmd.wdata = p1_wdata;
            sel_cmd.wmask = p1_wmask;
        end else begin
            sel_cmd.we    = p0_we;
            sel_cmd.k     = p0_k;
            sel_cmd.n     = p0_n;
            sel_cmd.wdata = p0_wdata;
            sel_cmd.wmask = p0_wmask;
        end
        push = acc && !sel_cmd.we;
    end

    // Next issued command and round-robin pointer
    always_comb begin
        rr_last_d = acc ? gnt_id : rr_last_q;
        issue_d   = acc;
        cmd_d     = '0;
        if (acc) begin
            cmd_d = sel_cmd;
            if (!sel_cmd.we) begin
                cmd_d.wdata = '0;
                cmd_d.wmask = '0;
            end
        end
    end

    sram_kn_tag_fifo #(
        .DEPTH (MAX_OUT),
        .CNT_W (CNT_W)
    ) u_tags (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_id (gnt_id),
        .pop     (x_rvalid),
        .pop_ok  (pop_ok),
        .pop_id  (pop_id),
        .stray   (stray),
        .count   (fifo_cnt)
    );

    // Route returning read data to the port at the FIFO head
    always_comb begin
        rsp_v_d = '0;
        rsp0_d  = rsp0_q;
        rsp1_d  = rsp1_q;
        err_d   = err_q || stray;
        if (pop_ok) begin
            if (pop_id == 1'(PORT_CONSUMER)) begin
                rsp_v_d[1] = 1'b1;
                rsp1_d     = x_rdata;
            end else begin
                rsp_v_d[0] = 1'b1;
                rsp0_d     = x_rdata;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_q     <= '0;
            issue_q   <= 1'b0;
            rr_last_q <= 1'b1;
            rsp_v_q   <= '0;
            rsp0_q    <= '0;
            rsp1_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            cmd_q     <= cmd_d;
            issue_q   <= issue_d;
            rr_last_q <= rr_last_d;
            rsp_v_q   <= rsp_v_d;
            rsp0_q    <= rsp0_d;
            rsp1_q    <= rsp1_d;
            err_q     <= err_d;
        end
    end

    assign x_en         = issue_q;
    assign x_re         = issue_q && !cmd_q.we;
    assign x_we         = issue_q && cmd_q.we;
    assign x_k          = cmd_q.k;
    assign x_n          = cmd_q.n;
    assign x_wdata      = cmd_q.wdata;
    assign x_wmask      = cmd_q.wmask;
    assign p0_rsp_valid = rsp_v_q[0];
    assign p1_rsp_valid = rsp_v_q[1];
    assign p0_rsp_data  = rsp0_q;
    assign p1_rsp_data  = rsp1_q;
    assign outstanding  = fifo_cnt;
    assign err_stray    = err_q;

endmodule

// File: tb/tb_sram_kn_arb.sv
// Bench for sram_kn_arb: directed scenarios plus random traffic.
// A transaction-level model predicts grants, commands and responses.
module tb_sram_kn_arb;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        pv [2];
    logic        pwe [2];
    logic [9:0]  pk [2];
    logic [2:0]  pn [2];
    logic [31:0] pwd [2];
    logic [3:0]  pwm [2];
    logic        p0_ready, p1_ready;
    logic        p0_rsp_valid, p1_rsp_valid;
    logic [31:0] p0_rsp_data, p1_rsp_data;
    logic        x_en, x_re, x_we;
    logic [9:0]  x_k;
    logic [2:0]  x_n;
    logic [31:0] x_wdata;
    logic [3:0]  x_wmask;
    logic [31:0] x_rdata_i;
    logic        x_rvalid_i;
    logic [2:0]  outstanding;
    logic        err_stray;

    always #5 clk = ~clk;

    sram_kn_arb dut (
        .clk          (clk),
        .rst          (rst_i),
        .p0_valid     (pv[0]),
        .p0_ready     (p0_ready),
        .p0_we        (pwe[0]),
        .p0_k         (pk[0]),
        .p0_n         (pn[0]),
        .p0_wdata     (pwd[0]),
        .p0_wmask     (pwm[0]),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rsp_data  (p0_rsp_data),
        .p1_valid     (pv[1]),
        .p1_ready     (p1_ready),
        .p1_we        (pwe[1]),
        .p1_k         (pk[1]),
        .p1_n         (pn[1]),
        .p1_wdata     (pwd[1]),
        .p1_wmask     (pwm[1]),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rsp_data  (p1_rsp_data),
        .x_en         (x_en),
        .x_re         (x_re),
        .x_we         (x_we),
        .x_k          (x_k),
        .x_n          (x_n),
        .x_wdata      (x_wdata),
        .x_wmask      (x_wmask),
        .x_rdata      (x_rdata_i),
        .x_rvalid     (x_rvalid_i),
        .outstanding  (outstanding),
        .err_stray    (err_stray)
    );

    typedef struct {
        int          port;
        logic [31:0] data;
    } rd_t;

    int          n_assert = 0;
    int          n_fail = 0;
    int          last_w = 1;
    rd_t         rq [$];
    logic [31:0] ref_mem [int];
    logic [31:0] sram_mem [int];
    logic [31:0] pend [$];
    bit          exp_en, exp_we;
    logic [9:0]  exp_k;
    logic [2:0]  exp_n;
    logic [31:0] exp_wd;
    logic [3:0]  exp_wm;
    bit          exp_rv [2];
    logic [31:0] exp_rd [2];
    bit          exp_err;
    bit          auto_rv;
    int          rv_prob;
    int          obs_rsp [2];

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] w,
                                          logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[b*8 +: 8] = w[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_get(int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    endfunction

    function automatic logic [31:0] sram_get(int idx);
        return sram_mem.exists(idx) ? sram_mem[idx] : 32'h0;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pv[0] = 1'b0;
        pv[1] = 1'b0;
    endtask

    task automatic req(int p, bit we, int k, int n, logic [31:0] wd,
                       logic [3:0] wm);
        pv[p]  = 1'b1;
        pwe[p] = we;
        pk[p]  = 10'(k);
        pn[p]  = 3'(n);
        pwd[p] = wd;
        pwm[p] = wm;
    endtask

    // One clock: check outputs, run SRAM + reference model, advance.
    task automatic step();
        bit e [2];
        bit room;
        int w;
        int idx;
        rd_t r;
        #1;
        room = (rq.size() < 4) || x_rvalid_i;
        for (int i = 0; i < 2; i++)
            e[i] = rst_i && pv[i] && (pwe[i] || room);
        w = -1;
        if (e[0] && e[1]) w = 1 - last_w;
        else if (e[0]) w = 0;
        else if (e[1]) w = 1;
        chk("p0_ready", p0_ready, w == 0);
        chk("p1_ready", p1_ready, w == 1);
        chk("outstanding", outstanding, rq.size());
        chk("x_en", x_en, exp_en);
        chk("x_re", x_re, exp_en && !exp_we);
        chk("x_we", x_we, exp_en && exp_we);
        if (exp_en) begin
            chk("x_k", x_k, exp_k);
            chk("x_n", x_n, exp_n);
            chk("x_wdata", x_wdata, exp_we ? exp_wd : 32'h0);
            chk("x_wmask", x_wmask, exp_we ? exp_wm : 4'h0);
        end
        chk("p0_rsp_valid", p0_rsp_valid, exp_rv[0]);
        chk("p1_rsp_valid", p1_rsp_valid, exp_rv[1]);
        chk("p0_rsp_data", p0_rsp_data, exp_rd[0]);
        chk("p1_rsp_data", p1_rsp_data, exp_rd[1]);
        chk("err_stray", err_stray, exp_err);
        if (p0_rsp_valid === 1'b1) obs_rsp[0]++;
        if (p1_rsp_valid === 1'b1) obs_rsp[1]++;
        // SRAM model executes whatever is on x_* this cycle
        idx = int'(x_k) * 8 + int'(x_n);
        if (x_en === 1'b1 && x_we === 1'b1)
            sram_mem[idx] = merge(sram_get(idx), x_wdata, x_wmask);
        else if (x_en === 1'b1 && x_re === 1'b1)
            pend.push_back(sram_get(idx));
        // Reference model update at the edge
        if (!rst_i) begin
            rq.delete();
            last_w    = 1;
            exp_en    = 1'b0;
            exp_rv[0] = 1'b0;
            exp_rv[1] = 1'b0;
            exp_rd[0] = 32'h0;
            exp_rd[1] = 32'h0;
            exp_err   = 1'b0;
        end else begin
            exp_en = (w >= 0);
            if (w >= 0) begin
                last_w = w;
                exp_we = pwe[w];
                exp_k  = pk[w];
                exp_n  = pn[w];
                exp_wd = pwd[w];
                exp_wm = pwm[w];
                idx    = int'(pk[w]) * 8 + int'(pn[w]);
                if (pwe[w]) begin
                    ref_mem[idx] = merge(ref_get(idx), pwd[w], pwm[w]);
                end else begin
                    r.port = w;
                    r.data = ref_get(idx);
                    rq.push_back(r);
                end
            end
            exp_rv[0] = 1'b0;
            exp_rv[1] = 1'b0;
            if (x_rvalid_i) begin
                if (rq.size() > 0) begin
                    r = rq.pop_front();
                    exp_rv[r.port] = 1'b1;
                    exp_rd[r.port] = r.data;
                end else begin
                    exp_err = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        x_rvalid_i = 1'b0;
        if (auto_rv && pend.size() > 0 &&
            $urandom_range(0, 99) < rv_prob) begin
            x_rvalid_i = 1'b1;
            x_rdata_i  = pend.pop_front();
        end
    endtask

    task automatic drain(int n);
        idle();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_i      = 1'b0;
        x_rvalid_i = 1'b0;
        x_rdata_i  = 32'h0;
        exp_en     = 1'b0;
        exp_we     = 1'b0;
        exp_rv[0]  = 1'b0;
        exp_rv[1]  = 1'b0;
        exp_rd[0]  = 32'h0;
        exp_rd[1]  = 32'h0;
        exp_err    = 1'b0;
        auto_rv    = 1'b1;
        rv_prob    = 100;
        obs_rsp[0] = 0;
        obs_rsp[1] = 0;
        req(0, 1'b0, 0, 0, 32'h0, 4'h0);
        req(1, 1'b0, 1, 0, 32'h0, 4'h0);
        @(posedge clk);
        #1;

        // Reset held with both requesters asking
        for (int i = 0; i < 3; i++) step();
        rst_i = 1'b1;
        step();
        drain(6);

        // Write then read the same location from the other port
        req(0, 1'b1, 5, 3, 32'hDEADBEEF, 4'hF);
        step();
        idle();
        req(1, 1'b0, 5, 3, 32'h0, 4'h0);
        step();
        idle();
        step();
        chk("raw_rsp_p1", p1_rsp_valid, 1'b0);
        step();
        chk("raw_rsp_p1_valid", p1_rsp_valid, 1'b1);
        chk("raw_rsp_p1_data", p1_rsp_data, 32'hDEADBEEF);
        chk("raw_rsp_p0_quiet", p0_rsp_valid, 1'b0);
        drain(4);

        // Both ports reading back to back: alternating grants
        obs_rsp[0] = 0;
        obs_rsp[1] = 0;
        for (int i = 0; i < 8; i++) begin
            req(0, 1'b0, 40 + i, 1, 32'h0, 4'h0);
            req(1, 1'b0, 60 + i, 2, 32'h0, 4'h0);
            step();
        end
        drain(6);
        chk("alt_rsp_p0", obs_rsp[0], 4);
        chk("alt_rsp_p1", obs_rsp[1], 4);

        // SRAM stalled: fill the read window, writes still pass
        auto_rv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req(1, 1'b0, 10 + i, 0, 32'h0, 4'h0);
            step();
        end
        idle();
        step();
        chk("full_out", outstanding, 3'd4);
        req(1, 1'b0, 14, 0, 32'h0, 4'h0);
        req(0, 1'b1, 15, 0, 32'hA5A5_0001, 4'h3);
        #1;
        chk("full_p1_blocked", p1_ready, 1'b0);
        chk("full_p0_write", p0_ready, 1'b1);
        step();
        pv[0] = 1'b0;
        x_rvalid_i = 1'b1;
        x_rdata_i  = pend.pop_front();
        #1;
        chk("pop_frees_slot", p1_ready, 1'b1);
        step();
        idle();
        step();
        chk("out_stays_full", outstanding, 3'd4);
        auto_rv = 1'b1;
        drain(10);

        // Reset with two reads in flight; late data is stray
        auto_rv = 1'b0;
        req(0, 1'b0, 20, 0, 32'h0, 4'h0);
        req(1, 1'b0, 21, 0, 32'h0, 4'h0);
        step();
        step();
        idle();
        step();
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        chk("rst_out", outstanding, 3'd0);
        x_rvalid_i = 1'b1;
        x_rdata_i  = pend.pop_front();
        step();
        step();
        chk("late_err", err_stray, 1'b1);
        chk("late_no_rsp0", p0_rsp_valid, 1'b0);
        chk("late_no_rsp1", p1_rsp_valid, 1'b0);
        pend.delete();

        // Stray return after clean reset, sticky until reset
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        chk("clean_err", err_stray, 1'b0);
        x_rvalid_i = 1'b1;
        x_rdata_i  = 32'h1234_5678;
        step();
        for (int i = 0; i < 3; i++) step();
        chk("stray_sticky", err_stray, 1'b1);
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        chk("stray_cleared", err_stray, 1'b0);

        // Random mixed traffic
        auto_rv = 1'b1;
        rv_prob = 60;
        for (int i = 0; i < 300; i++) begin
            for (int p = 0; p < 2; p++) begin
                pv[p]  = 1'($urandom_range(0, 1));
                pwe[p] = 1'($urandom_range(0, 1));
                pk[p]  = 10'($urandom_range(0, 3));
                pn[p]  = 3'($urandom_range(0, 1));
                pwd[p] = $urandom;
                pwm[p] = 4'($urandom_range(0, 15));
            end
            step();
        end
        rv_prob = 100;
        drain(12);
        chk("final_out", outstanding, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
